// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one iteration per clock, with a PC stall while the operation is in flight.
module muldiv_sequencer #(
   parameter int XLEN = 32,
   localparam int CNT_W = $clog2(XLEN)
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic            EN_PC,
   input  logic [6:0]      opcode,
   input  logic [2:0]      Funct3,
   input  logic            Funct7_0,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output logic            stall,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_t state_q, state_d;

   logic [2:0]       op_q;
   logic             neg_q;
   logic [XLEN-1:0]  opnd_q;   // multiplicand magnitude (mul) or divisor magnitude (div)
   logic [XLEN-1:0]  hi_q;     // product high half (mul) or partial remainder (div)
   logic [XLEN-1:0]  lo_q;     // multiplier bits (mul) or dividend/quotient bits (div)
   logic [CNT_W-1:0] cnt_q;

   logic            start_req;
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;
   logic            res_neg;

   always_comb begin
      start_req = EN_PC & (opcode == 7'b0110011) & Funct7_0 & (state_q == IDLE);
      a_signed  = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
      b_signed  = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
      a_neg     = a_signed & rs1_data[XLEN-1];
      b_neg     = b_signed & rs2_data[XLEN-1];
      a_mag     = a_neg ? -rs1_data : rs1_data;
      b_mag     = b_neg ? -rs2_data : rs2_data;
      div_zero  = Funct3[2] & (rs2_data == '0);
      div_ovf   = Funct3[2] & ~Funct3[0] & (rs1_data == MIN_VAL) & (rs2_data == '1);
      special   = div_zero | div_ovf;
      if (div_zero)
         special_res = Funct3[1] ? rs1_data : '1;
      else
         special_res = Funct3[1] ? '0 : MIN_VAL;
      // Remainder follows the dividend sign; quotient and product follow sign(A)^sign(B).
      res_neg = (Funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
   end

   // One iteration of either algorithm.
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift, div_diff;
   logic [XLEN-1:0]   hi_n, lo_n;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quot_s, rem_s, final_res;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      hi_n      = hi_q;
      lo_n      = lo_q;
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_n = div_diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_n = div_shift[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      prod   = {hi_n, lo_n};
      prod_s = neg_q ? -prod : prod;
      quot_s = neg_q ? -lo_n : lo_n;
      rem_s  = neg_q ? -hi_n : hi_n;
      if (op_q[2])
         final_res = op_q[1] ? rem_s : quot_s;
      else
         final_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_req) state_d = special ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         op_q   <= '0;
         neg_q  <= 1'b0;
         opnd_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         result <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_req) begin
                  op_q   <= Funct3;
                  neg_q  <= res_neg;
                  opnd_q <= Funct3[2] ? b_mag : a_mag;
                  lo_q   <= Funct3[2] ? a_mag : b_mag;
                  hi_q   <= '0;
                  cnt_q  <= CNT_W'(XLEN-1);
                  if (special) result <= special_res;
               end
            end
            CALC: begin
               hi_q  <= hi_n;
               lo_q  <= lo_n;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) result <= final_res;
            end
            default: ;
         endcase
      end
   end

   assign stall        = start_req | (state_q == CALC);
   assign busy         = (state_q == CALC);
   assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_pc;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_0;
   logic [31:0] rs1_data, rs2_data;
   logic        stall, busy, result_valid;
   logic [31:0] result;

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   localparam logic [6:0] OP_R = 7'b0110011;

   muldiv_sequencer #(.XLEN(32)) dut (
      .CLK(clk), .rst(rst), .EN_PC(en_pc), .opcode(opcode), .Funct3(funct3),
      .Funct7_0(funct7_0), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .busy(busy), .result_valid(result_valid), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions using 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint p;
      logic [63:0] pv;
      int sa, sb;
      sa = a;
      sb = b;
      case (f3)
         3'b000: begin p = longint'(sa) * longint'(sb); pv = p; return pv[31:0]; end
         3'b001: begin p = longint'(sa) * longint'(sb); pv = p; return pv[63:32]; end
         3'b010: begin p = longint'(sa) * longint'({32'b0, b}); pv = p; return pv[63:32]; end
         3'b011: begin pv = {32'b0, a} * {32'b0, b}; return pv[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   task automatic idle_inputs();
      opcode   = 7'h13;
      funct7_0 = 1'b0;
      en_pc    = 1'b1;
      funct3   = 3'b000;
      rs1_data = $urandom;
      rs2_data = $urandom;
   endtask

   // Issues one M instruction, scrambles operands after the start cycle, and checks
   // result, latency, stall/busy length and the single-cycle valid pulse.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat, stalls, busies;
      logic [31:0] e;
      @(negedge clk);
      opcode = OP_R; funct7_0 = 1'b1; en_pc = 1'b1;
      funct3 = f3; rs1_data = a; rs2_data = b;
      exp_q.push_back(exp);
      #1 chk({name, " start_stall"}, {31'b0, stall}, 32'd1);
      @(negedge clk);
      idle_inputs();
      lat = 1; stalls = 0; busies = 0;
      while (!result_valid && lat < 100) begin
         if (stall) stalls++;
         if (busy) busies++;
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " stall_cycles"}, stalls, exp_lat - 1);
      chk({name, " busy_cycles"}, busies, exp_lat - 1);
      chk({name, " done_stall"}, {31'b0, stall}, 32'd0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk({name, " result"}, result, e);
      @(negedge clk);
      chk({name, " valid_pulse"}, {31'b0, result_valid}, 32'd0);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a, b, exp;
      int          lat;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int viol, v1, v2, cyc;
      logic [2:0]  f3;
      logic [31:0] a, b;

      tbl[0]  = '{"mul_7x-3",      3'b000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      tbl[1]  = '{"mulhu_ff",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      tbl[2]  = '{"mulh_ff",       3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33};
      tbl[3]  = '{"mulhsu_ff",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      tbl[4]  = '{"div_-20_6",     3'b100, 32'hFFFF_FFEC, 32'h6,         32'hFFFF_FFFD, 33};
      tbl[5]  = '{"rem_-20_6",     3'b110, 32'hFFFF_FFEC, 32'h6,         32'hFFFF_FFFE, 33};
      tbl[6]  = '{"divu_20_6",     3'b101, 32'd20,        32'd6,         32'd3,         33};
      tbl[7]  = '{"remu_20_6",     3'b111, 32'd20,        32'd6,         32'd2,         33};
      tbl[8]  = '{"divu_5_0",      3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      tbl[9]  = '{"rem_5_0",       3'b110, 32'd5,         32'd0,         32'd5,         1};
      tbl[10] = '{"div_min_-1",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      tbl[11] = '{"rem_min_-1",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
      tbl[12] = '{"mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      tbl[13] = '{"div_min_2",     3'b100, 32'h8000_0000, 32'h2,         32'hC000_0000, 33};

      rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_busy",   {31'b0, busy},         32'd0);
      chk("reset_valid",  {31'b0, result_valid}, 32'd0);
      chk("reset_stall",  {31'b0, stall},        32'd0);
      chk("reset_result", result,                32'd0);

      foreach (tbl[i]) run_op(tbl[i].name, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);

      // Reset during CALC: operation is dropped, no result pulse afterwards.
      @(negedge clk);
      opcode = OP_R; funct7_0 = 1'b1; en_pc = 1'b1; funct3 = 3'b000;
      rs1_data = 32'd9; rs2_data = 32'd9;
      @(negedge clk);
      idle_inputs();
      repeat (9) @(negedge clk);
      chk("mid_calc_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_busy",   {31'b0, busy},  32'd0);
      chk("post_rst_stall",  {31'b0, stall}, 32'd0);
      chk("post_rst_result", result,         32'd0);
      viol = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_valid || busy || stall) viol++;
      end
      chk("post_rst_quiet", viol, 0);
      run_op("mul_after_rst", 3'b000, 32'd12345, 32'd678, 32'd8369910, 33);

      // Non-M R-type and M instruction with pipeline disabled must never start.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         opcode = OP_R; funct3 = 3'b100; rs1_data = 32'd100; rs2_data = 32'd7;
         funct7_0 = (k == 0) ? 1'b0 : 1'b1;
         en_pc    = (k == 0) ? 1'b1 : 1'b0;
         viol = 0;
         repeat (40) begin
            #1 if (result_valid || busy || stall) viol++;
            @(negedge clk);
         end
         chk((k == 0) ? "non_m_idle" : "en_pc_low_idle", viol, 0);
         idle_inputs();
      end

      // M instruction held on the inputs: DONE blocks reissue, next IDLE restarts it.
      @(negedge clk);
      opcode = OP_R; funct7_0 = 1'b1; en_pc = 1'b1; funct3 = 3'b000;
      rs1_data = 32'd3; rs2_data = 32'd5;
      v1 = -1; v2 = -1; viol = 0;
      for (cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         #1;
         if (result_valid) begin
            if (stall) viol++;
            if (result !== 32'd15) viol++;
            if (v1 < 0) v1 = cyc;
            else if (v2 < 0) v2 = cyc;
         end
      end
      idle_inputs();
      chk("b2b_first_valid",  v1, 33);
      chk("b2b_second_valid", v2, 67);
      chk("b2b_done_checks",  viol, 0);
      repeat (40) @(negedge clk);

      // Random operations, biased toward the divide special cases.
      for (int n = 0; n < 150; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            default: ;
         endcase
         run_op($sformatf("rand%0d_f%0d", n, f3), f3, a, b, ref_model(f3, a, b),
                ref_latency(f3, a, b));
      end

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
